// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR filter blocks: default widths, the MAC
// sequencer state type, and the round/convert function used to turn a wide
// accumulator into a DATA_W-bit output sample.
//
// Optional feature macro: FIR_SAT_EN
//   defined   -> fir_round_convert clamps to the signed DATA_W range
//   undefined -> fir_round_convert keeps the low DATA_W bits (two's-complement wrap)
package fir_pkg;

    localparam int TAPS      = 64;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 38;   // 2*DATA_W + $clog2(TAPS): cannot overflow
    localparam int OUT_SHIFT = 15;   // Q15 coefficients
    localparam int TAP_W     = $clog2(TAPS);
    localparam int PROD_W    = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        ROUND,
        OUT
    } fir_state_t;

    // Round half up, arithmetic shift by OUT_SHIFT, then convert to DATA_W.
    function automatic logic [DATA_W-1:0] fir_round_convert(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] r;
`ifdef FIR_SAT_EN
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
`endif
        half   = ACC_W'(1) << (OUT_SHIFT - 1);
        biased = acc + half;
        r      = biased >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        hi = ACC_W'((1 << (DATA_W - 1)) - 1);
        lo = ~hi;                     // -2^(DATA_W-1)
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
`endif
        return DATA_W'(r);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
// Bundles every non-clock signal of the FIR MAC sequencer.
//   Sample input : in_valid, in_ready, in_sample
//   Delay line   : sr_in_data, sr_write, sr_rd_reg, sr_rd_data (combinational read)
//   Coef ROM     : coef_addr, coef_data (combinational read)
//   Result output: out_valid, out_ready, out_data
// Modports: master = the sequencer, slave = its environment.
//
// Handshake rule for both in_* and out_* ports: a transfer happens at a
// rising clock edge where valid and ready are both 1. A producer holding
// valid keeps its data stable until that edge; valid never waits on ready.
interface fir_mac_sequencer_if;
    import fir_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;

    logic [DATA_W-1:0] sr_in_data;
    logic              sr_write;
    logic [TAP_W-1:0]  sr_rd_reg;
    logic [DATA_W-1:0] sr_rd_data;

    logic [TAP_W-1:0]  coef_addr;
    logic [DATA_W-1:0] coef_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_valid, in_sample, sr_rd_data, coef_data, out_ready,
        output in_ready, sr_in_data, sr_write, sr_rd_reg, coef_addr, out_valid, out_data
    );

    modport slave (
        output in_valid, in_sample, sr_rd_data, coef_data, out_ready,
        input  in_ready, sr_in_data, sr_write, sr_rd_reg, coef_addr, out_valid, out_data
    );

endinterface

// File: rtl/fir_mac_unit.sv
// fir_mac_unit
// Signed DATA_W x DATA_W multiplier, ACC_W accumulator and the registered
// round/convert output stage.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : zero the accumulator (takes priority over enable)
//   enable       : accumulate sample*coef this cycle
//   load         : register the rounded/converted accumulator into result
//   sample, coef : signed operands
//   result       : registered output sample
// Conversion mode follows FIR_SAT_EN through fir_pkg::fir_round_convert.
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] coef,
    output logic [DATA_W-1:0] result
);

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc;

    assign product = $signed(sample) * $signed(coef);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (enable) begin
                // Size cast of a signed product sign-extends to ACC_W.
                acc <= acc + ACC_W'(product);
            end
            if (load) begin
                result <= fir_round_convert(acc);
            end
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Read-side controller for the FIR delay line. Accepts one sample, shifts it
// into the delay line, walks taps 0..TAPS-1 through the MAC unit, rounds the
// result and offers it on the output handshake.
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high
//   bus       : fir_mac_sequencer_if.master (sample in, delay line, coef ROM, result out)
//   fsm_state : current FSM state, for observation
// Optional feature macro: FIR_SAT_EN (output saturation, see fir_pkg).
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    fir_mac_sequencer_if.master     bus,
    output fir_state_t              fsm_state
);

    fir_state_t        state_q;
    fir_state_t        state_d;
    logic [TAP_W-1:0]  k_q;
    logic [DATA_W-1:0] sample_q;
    logic [TAP_W-1:0]  rd_idx;
    logic              acc_clear;
    logic              acc_enable;
    logic              out_load;

    assign fsm_state      = state_q;
    assign bus.sr_in_data = sample_q;
    assign bus.sr_rd_reg  = rd_idx;
    assign bus.coef_addr  = rd_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.in_valid) begin
                sample_q <= bus.in_sample;
            end
            if (state_q == SHIFT) begin
                k_q <= '0;
            end else if (state_q == MAC) begin
                k_q <= k_q + TAP_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.sr_write  = 1'b0;
        bus.out_valid = 1'b0;
        rd_idx        = '0;
        acc_clear     = 1'b0;
        acc_enable    = 1'b0;
        out_load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_clear = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Delay line shifts at the end of this cycle, so tap 0
                // already holds the new sample in the first MAC cycle.
                bus.sr_write = 1'b1;
                state_d      = MAC;
            end
            MAC: begin
                rd_idx     = k_q;
                acc_enable = 1'b1;
                if (k_q == TAP_W'(TAPS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_load = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fir_mac_unit u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .enable (acc_enable),
        .load   (out_load),
        .sample (bus.sr_rd_data),
        .coef   (bus.coef_data),
        .result (bus.out_data)
    );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    logic       clock;
    logic       reset;
    fir_state_t fsm_state;

    fir_mac_sequencer_if bus();

    fir_mac_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.master),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- environment: delay line and coefficient ROM ----------------
    logic signed [15:0] dl[64];
    logic signed [15:0] coef_rom[64];
    logic               dl_clear;

    always @(posedge clock) begin
        if (dl_clear) begin
            for (int i = 0; i < 64; i++) dl[i] <= '0;
        end else if (bus.sr_write) begin
            dl[0] <= bus.sr_in_data;
            for (int i = 1; i < 64; i++) dl[i] <= dl[i-1];
        end
    end

    assign bus.sr_rd_data = dl[bus.sr_rd_reg];
    assign bus.coef_data  = coef_rom[bus.coef_addr];

    // ---------------- scoreboard ----------------
    logic [15:0]        exp_q[$];
    logic signed [15:0] hist[64];
    int                 n_checks;
    int                 n_fail;
    bit                 rand_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 64; k++) acc += longint'(hist[k]) * longint'(coef_rom[k]);
        r = (acc + 16384) >>> 15;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // Record an accepted sample: shift the reference history, queue the result.
    task automatic accept(input logic [15:0] s);
        for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        exp_q.push_back(model());
    endtask

    // One clock: observe outputs at the falling edge, then drive after the rising edge.
    task automatic step();
        logic [15:0] e;
        @(negedge clock);
        if (!reset && bus.out_valid && bus.out_ready) begin
            check("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e));
            end
        end
        @(posedge clock);
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] s);
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus.in_ready) begin
                accept(s);
                done = 1'b1;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || !bus.in_ready); i++) step();
        check("drain_done", 32'(exp_q.size() == 0 && bus.in_ready), 32'd1);
    endtask

    task automatic set_coefs(input logic [15:0] c, input bit rnd);
        for (int k = 0; k < 64; k++) coef_rom[k] = rnd ? 16'($urandom_range(0, 65535)) : c;
    endtask

    task automatic latency_test(input logic [15:0] s);
        int exp_idx;
        check("lat_start_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        accept(s);
        step();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 67; c++) begin
            exp_idx = (c >= 2 && c <= 65) ? c - 2 : 0;
            check("lat_sr_write", 32'(bus.sr_write), 32'(c == 1));
            check("lat_sr_rd_reg", 32'(bus.sr_rd_reg), 32'(exp_idx));
            check("lat_coef_addr", 32'(bus.coef_addr), 32'(exp_idx));
            check("lat_out_valid", 32'(bus.out_valid), 32'(c == 67));
            check("lat_in_ready", 32'(bus.in_ready), 32'd0);
            if (c == 1) check("lat_sr_in_data", 32'(bus.sr_in_data), 32'(s));
            step();
        end
    endtask

    task automatic backpressure_test(input logic [15:0] s, input logic [15:0] s2);
        int pulses;
        bus.out_ready = 1'b0;
        send(s);
        for (int i = 0; i < 100 && !bus.out_valid; i++) step();
        check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_sample = s2;
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            if (exp_q.size() != 0) check("bp_out_data", 32'(bus.out_data), 32'(exp_q[0]));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sr_write", 32'(bus.sr_write), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_idle_after_out", 32'(bus.in_ready), 32'd1);
        accept(s2);
        step();
        pulses = 0;
        for (int c = 0; c < 66; c++) begin
            if (bus.sr_write) pulses++;
            check("bp_busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (c == 4) bus.in_valid = 1'b0;
            step();
        end
        check("bp_one_accept", 32'(pulses), 32'd1);
        drain();
    endtask

    task automatic reset_mid_test(input logic [15:0] s, input logic [15:0] s2);
        send(s);
        for (int i = 0; i < 100 && bus.sr_rd_reg != 6'd20; i++) step();
        check("rst_reached_k20", 32'(bus.sr_rd_reg), 32'd20);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sr_rd_reg", 32'(bus.sr_rd_reg), 32'd0);
        check("rst_coef_addr", 32'(bus.coef_addr), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        send(s2);
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rand_rdy      = 1'b0;
        reset         = 1'b1;
        dl_clear      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            hist[k]     = '0;
            coef_rom[k] = '0;
        end
        step();
        step();
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_sr_write", 32'(bus.sr_write), 32'd0);
        check("reset_sr_in_data", 32'(bus.sr_in_data), 32'd0);
        check("reset_sr_rd_reg", 32'(bus.sr_rd_reg), 32'd0);
        check("reset_coef_addr", 32'(bus.coef_addr), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        reset    = 1'b0;
        dl_clear = 1'b0;
        step();

        // Impulse response with schedule check on the first sample.
        set_coefs(16'h2000, 1'b0);
        latency_test(16'h4000);
        for (int i = 0; i < 64; i++) send(16'h0000);
        drain();

        backpressure_test(16'h1234, 16'hF00D);
        reset_mid_test(16'h2222, 16'h0777);

        // Positive and negative full-scale accumulation.
        set_coefs(16'h7FFF, 1'b0);
        for (int i = 0; i < 64; i++) send(16'h7FFF);
        drain();
        for (int i = 0; i < 64; i++) send(16'h8000);
        drain();

        // Random coefficients, samples, gaps and output readiness.
        set_coefs(16'h0000, 1'b1);
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 5)) step();
            send(16'($urandom_range(0, 65535)));
        end
        drain();
        rand_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
